// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and the
// hardwired-zero register specifier.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             clr_ni,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch squashes and
// multi-cycle mult/div holds, driving per-stage write enables and flushes.
module pipe_hazard_ctrl #(
    parameter int REG_W      = 5,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_md_start_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             ex_branch_taken_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_we_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             md_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    import hazard_pkg::*;

    localparam int MD_CW = $clog2(MD_LATENCY);

    state_e           state_q, state_d;
    logic [MD_CW-1:0] md_cnt_q, md_cnt_d;
    logic             load_use;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_read_i && (ex_rt_i != REG_W'(REG_ZERO)) &&
                      ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

    always_comb begin
        pc_we_o       = 1'b1;
        ifid_we_o     = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_we_o     = 1'b1;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        md_busy_o     = 1'b0;
        state_d       = state_q;
        md_cnt_d      = md_cnt_q;

        if (!reset_i) begin
            pc_we_o       = 1'b0;
            ifid_we_o     = 1'b0;
            idex_we_o     = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
            state_d       = RUN;
            md_cnt_d      = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_branch_taken_i) begin
                        ifid_flush_o = 1'b1;
                        idex_flush_o = 1'b1;
                    end else if (load_use) begin
                        pc_we_o      = 1'b0;
                        ifid_we_o    = 1'b0;
                        idex_flush_o = 1'b1;
                    end else if (id_md_start_i) begin
                        state_d  = MD_WAIT;
                        md_cnt_d = MD_CW'(MD_LATENCY - 1);
                    end
                end
                MD_WAIT: begin
                    pc_we_o       = 1'b0;
                    ifid_we_o     = 1'b0;
                    idex_we_o     = 1'b0;
                    exmem_flush_o = 1'b1;
                    md_busy_o     = 1'b1;
                    md_cnt_d      = md_cnt_q - MD_CW'(1);
                    if (md_cnt_q == MD_CW'(1)) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Reset cycles are excluded from the stall count by the clear taking priority.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .clr_ni (reset_i),
        .en_i   (!pc_we_o),
        .cnt_o  (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, load-use, branch priority,
// mult/div hold, reset abort and stall counter saturation.
module tb_pipe_hazard_ctrl;

    localparam int REG_W      = 5;
    localparam int MD_LATENCY = 4;
    localparam int CNT_W      = 4;

    // Control vector: {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush, md_busy}
    localparam logic [6:0] CTL_RESET  = 7'b0010110;
    localparam logic [6:0] CTL_NORMAL = 7'b1101000;
    localparam logic [6:0] CTL_LDUSE  = 7'b0001100;
    localparam logic [6:0] CTL_BRANCH = 7'b1111100;
    localparam logic [6:0] CTL_MDWAIT = 7'b0000011;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             id_uses_rt, id_md_start, ex_mem_read, ex_branch_taken;
    logic             pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush, md_busy;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_W      (REG_W),
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .id_rs_i           (id_rs),
        .id_rt_i           (id_rt),
        .id_uses_rt_i      (id_uses_rt),
        .id_md_start_i     (id_md_start),
        .ex_mem_read_i     (ex_mem_read),
        .ex_rt_i           (ex_rt),
        .ex_branch_taken_i (ex_branch_taken),
        .pc_we_o           (pc_we),
        .ifid_we_o         (ifid_we),
        .ifid_flush_o      (ifid_flush),
        .idex_we_o         (idex_we),
        .idex_flush_o      (idex_flush),
        .exmem_flush_o     (exmem_flush),
        .md_busy_o         (md_busy),
        .stall_cnt_o       (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [REG_W-1:0] ert, input logic [REG_W-1:0] irs,
                         input logic [REG_W-1:0] irt, input logic urt, input logic md,
                         input logic br);
        ex_mem_read     = rd;
        ex_rt           = ert;
        id_rs           = irs;
        id_rt           = irt;
        id_uses_rt      = urt;
        id_md_start     = md;
        ex_branch_taken = br;
    endtask

    // Checks one cycle at the falling edge, then advances just past the next rising edge.
    task automatic cycle(input string tag, input logic [6:0] exp_ctl, input int exp_stall);
        logic [6:0] ctl;
        @(negedge clk);
        ctl = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush, md_busy};
        $display("cycle %-12s ctl=%b stall_cnt=%0d", tag, ctl, stall_cnt);
        check({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl));
        check({tag, "_cnt"}, 32'(stall_cnt), 32'(exp_stall));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Reset held two cycles, inputs that would otherwise stall are ignored.
        cycle("reset0", CTL_RESET, 0);
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle("reset1", CTL_RESET, 0);
        reset = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cycle("run_idle", CTL_NORMAL, 0);

        // Load-use on rs, then on rt, then rt-not-used and register-zero cases.
        drive(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0);
        cycle("lduse_rs", CTL_LDUSE, 0);
        drive(1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        cycle("after_rs", CTL_NORMAL, 1);
        drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
        cycle("lduse_rt", CTL_LDUSE, 1);
        drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
        cycle("rt_unused", CTL_NORMAL, 2);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        cycle("ld_r0", CTL_NORMAL, 2);
        drive(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        cycle("no_load", CTL_NORMAL, 2);

        // Branch outranks a load-use match and a mult/div start.
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
        cycle("branch", CTL_BRANCH, 2);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cycle("post_branch", CTL_NORMAL, 2);

        // Load-use outranks md_start; md_start then re-evaluated and taken.
        drive(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle("ld_over_md", CTL_LDUSE, 2);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle("md_start", CTL_NORMAL, 3);
        drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1);
        cycle("md_wait1", CTL_MDWAIT, 3);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cycle("md_wait2", CTL_MDWAIT, 4);
        cycle("md_wait3", CTL_MDWAIT, 5);
        cycle("md_done", CTL_NORMAL, 6);

        // Reset in the second MD_WAIT cycle aborts the hold.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle("md2_start", CTL_NORMAL, 6);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cycle("md2_wait1", CTL_MDWAIT, 6);
        reset = 1'b0;
        cycle("md2_reset", CTL_RESET, 7);
        reset = 1'b1;
        cycle("md2_after", CTL_NORMAL, 0);

        // Twenty consecutive stalls saturate the 4-bit counter at 15.
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle($sformatf("sat%0d", i), CTL_LDUSE, (i < 15) ? i : 15);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cycle("sat_hold", CTL_NORMAL, 15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
